// File: rtl/wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_arbiter_if                                          |
// | Description : Write-back arbiter bus bundle: ALU and LSU result      |
// |               handshakes, register-file write port and decode-stage  |
// |               forwarding lookups.                                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface wb_arbiter_if #(
   parameter int REG_WIDTH = 64
);
   logic                 alu_valid_i;
   logic                 alu_ready_o;
   logic [4:0]           alu_rd_i;
   logic [REG_WIDTH-1:0] alu_data_i;

   logic                 lsu_valid_i;
   logic                 lsu_ready_o;
   logic [4:0]           lsu_rd_i;
   logic [REG_WIDTH-1:0] lsu_data_i;

   logic [4:0]           rd_addr_o;
   logic                 rd_wen_o;
   logic [REG_WIDTH-1:0] result_o;

   logic [4:0]           rs1_addr_i;
   logic [4:0]           rs2_addr_i;
   logic                 rs1_fwd_o;
   logic                 rs2_fwd_o;
   logic [REG_WIDTH-1:0] rs1_fwd_data_o;
   logic [REG_WIDTH-1:0] rs2_fwd_data_o;

   // Arbiter side
   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  rs1_addr_i, rs2_addr_i,
      output alu_ready_o, lsu_ready_o,
      output rd_addr_o, rd_wen_o, result_o,
      output rs1_fwd_o, rs2_fwd_o, rs1_fwd_data_o, rs2_fwd_data_o
   );

   // Pipeline side (execution units, register file, decode)
   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output lsu_valid_i, lsu_rd_i, lsu_data_i,
      output rs1_addr_i, rs2_addr_i,
      input  alu_ready_o, lsu_ready_o,
      input  rd_addr_o, rd_wen_o, result_o,
      input  rs1_fwd_o, rs2_fwd_o, rs1_fwd_data_o, rs2_fwd_data_o
   );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_arbiter                                             |
// | Description : Register-file write-back arbiter. ALU results have     |
// |               priority; LSU results queue in a small FIFO and are    |
// |               guaranteed a slot every fourth cycle. The registered   |
// |               write port also feeds decode-stage forwarding.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wb_arbiter #(
   parameter int REG_WIDTH  = 64,
   parameter int FIFO_DEPTH = 2
) (
   input  wire logic     clk_sys_i,
   input  wire logic     rst_i,
   wb_arbiter_if.slave   bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [4:0]           rd;
      logic [REG_WIDTH-1:0] data;
   } entry_t;

   entry_t               fifo_mem_q [FIFO_DEPTH];
   entry_t               fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [1:0]           starv_q, starv_d;
   logic                 rd_wen_q, rd_wen_d;
   logic [4:0]           rd_addr_q, rd_addr_d;
   logic [REG_WIDTH-1:0] result_q, result_d;

   logic   fifo_ne;
   logic   fifo_full;
   logic   force_fifo;
   logic   alu_ready;
   logic   lsu_ready;
   logic   alu_write;
   logic   pop;
   logic   push;
   entry_t head;

   // Occupancy flags come from the registered count, so a same-cycle pop
   // never reopens a full FIFO. The head wins whenever the ALU does not
   // write: forced by starvation, ALU idle, or ALU targeting x0.
   always_comb begin
      fifo_ne    = (count_q != '0);
      fifo_full  = (count_q == DEPTH_C);
      force_fifo = (starv_q == 2'd3) && fifo_ne;
      lsu_ready  = !rst_i && !fifo_full;
      alu_ready  = !rst_i && bus.alu_valid_i && !force_fifo;
      alu_write  = alu_ready && (bus.alu_rd_i != 5'd0);
      pop        = !rst_i && fifo_ne && !alu_write;
      push       = bus.lsu_valid_i && lsu_ready && (bus.lsu_rd_i != 5'd0);
      head       = fifo_mem_q[rd_ptr_q];
   end

   // Next-state for FIFO, starvation counter and the write-port registers
   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      starv_d    = starv_q;
      rd_wen_d   = 1'b0;
      rd_addr_d  = 5'd0;
      result_d   = '0;

      if (push) begin
         fifo_mem_d[wr_ptr_q] = '{rd: bus.lsu_rd_i, data: bus.lsu_data_i};
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // Counter only runs while LSU work waits behind a writing ALU
      if (!fifo_ne || pop) begin
         starv_d = 2'd0;
      end else if (alu_write) begin
         starv_d = starv_q + 2'd1;
      end

      if (alu_write) begin
         rd_wen_d  = 1'b1;
         rd_addr_d = bus.alu_rd_i;
         result_d  = bus.alu_data_i;
      end else if (pop) begin
         rd_wen_d  = 1'b1;
         rd_addr_d = head.rd;
         result_d  = head.data;
      end
   end

   // Control and write-port registers with synchronous reset
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starv_q   <= 2'd0;
         rd_wen_q  <= 1'b0;
         rd_addr_q <= 5'd0;
         result_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starv_q   <= starv_d;
         rd_wen_q  <= rd_wen_d;
         rd_addr_q <= rd_addr_d;
         result_q  <= result_d;
      end
   end

   // FIFO storage needs no reset: push is blocked while rst_i is high
   always_ff @(posedge clk_sys_i) begin
      fifo_mem_q <= fifo_mem_d;
   end

   // Write port is masked during reset so a result presented as reset
   // asserts never reaches the register file or the forwarding path.
   always_comb begin
      bus.alu_ready_o = alu_ready;
      bus.lsu_ready_o = lsu_ready;
      bus.rd_wen_o    = rd_wen_q && !rst_i;
      bus.rd_addr_o   = rst_i ? 5'd0 : rd_addr_q;
      bus.result_o    = rst_i ? '0 : result_q;
   end

   // Decode-stage forwarding from the write port; x0 never forwards
   always_comb begin
      bus.rs1_fwd_o      = bus.rd_wen_o && (bus.rd_addr_o == bus.rs1_addr_i) &&
                           (bus.rs1_addr_i != 5'd0);
      bus.rs2_fwd_o      = bus.rd_wen_o && (bus.rd_addr_o == bus.rs2_addr_i) &&
                           (bus.rs2_addr_i != 5'd0);
      bus.rs1_fwd_data_o = bus.rs1_fwd_o ? bus.result_o : '0;
      bus.rs2_fwd_data_o = bus.rs2_fwd_o ? bus.result_o : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_wb_arbiter                                          |
// | Description : Randomized self-checking bench for wb_arbiter against  |
// |               a queue-based write-back reference model.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_wb_arbiter;

   localparam int RW     = 64;
   localparam int DEPTH  = 2;
   localparam int CYCLES = 2000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   wb_arbiter_if #(.REG_WIDTH(RW)) bus ();

   wb_arbiter #(
      .REG_WIDTH  (RW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_sys_i (clk),
      .rst_i     (rst),
      .bus       (bus)
   );

   typedef struct {
      logic [4:0]    rd;
      logic [RW-1:0] data;
   } ent_t;

   // Reference model: pending LSU results in acceptance order, number of
   // consecutive cycles the waiting LSU work lost to the ALU, and the write
   // that will be visible on the register-file port this cycle.
   ent_t          lsu_q [$];
   int            lost_cycles;
   bit            m_wen;
   logic [4:0]    m_addr;
   logic [RW-1:0] m_data;
   bit            alu_consumed;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Compare all outputs for the current cycle, then advance the model
   // across the coming clock edge.
   task automatic model_cycle();
      bit            exp_lrdy, exp_ardy, forced, alu_wr, had_work, exp_wen, f1, f2;
      ent_t          e;
      exp_lrdy = 1'b0;
      exp_ardy = 1'b0;
      if (!rst) begin
         exp_lrdy = (lsu_q.size() < DEPTH);
         forced   = (lost_cycles == 3) && (lsu_q.size() > 0);
         exp_ardy = bus.alu_valid_i && !forced;
      end
      check("lsu_ready", RW'(bus.lsu_ready_o), RW'(exp_lrdy));
      check("alu_ready", RW'(bus.alu_ready_o), RW'(exp_ardy));

      exp_wen = m_wen && !rst;
      check("rd_wen", RW'(bus.rd_wen_o), RW'(exp_wen));
      if (exp_wen) begin
         check("rd_addr", RW'(bus.rd_addr_o), RW'(m_addr));
         check("result", bus.result_o, m_data);
      end

      f1 = exp_wen && (bus.rs1_addr_i == m_addr) && (bus.rs1_addr_i != 5'd0);
      f2 = exp_wen && (bus.rs2_addr_i == m_addr) && (bus.rs2_addr_i != 5'd0);
      check("rs1_fwd", RW'(bus.rs1_fwd_o), RW'(f1));
      check("rs1_fwd_data", bus.rs1_fwd_data_o, f1 ? m_data : '0);
      check("rs2_fwd", RW'(bus.rs2_fwd_o), RW'(f2));
      check("rs2_fwd_data", bus.rs2_fwd_data_o, f2 ? m_data : '0);

      alu_consumed = exp_ardy;
      if (rst) begin
         lsu_q.delete();
         lost_cycles = 0;
         m_wen       = 1'b0;
      end else begin
         alu_wr   = exp_ardy && (bus.alu_rd_i != 5'd0);
         had_work = (lsu_q.size() > 0);
         if (alu_wr) begin
            m_wen       = 1'b1;
            m_addr      = bus.alu_rd_i;
            m_data      = bus.alu_data_i;
            lost_cycles = had_work ? lost_cycles + 1 : 0;
         end else if (had_work) begin
            e           = lsu_q.pop_front();
            m_wen       = 1'b1;
            m_addr      = e.rd;
            m_data      = e.data;
            lost_cycles = 0;
         end else begin
            m_wen       = 1'b0;
            lost_cycles = 0;
         end
         if (bus.lsu_valid_i && exp_lrdy && (bus.lsu_rd_i != 5'd0)) begin
            e.rd   = bus.lsu_rd_i;
            e.data = bus.lsu_data_i;
            lsu_q.push_back(e);
         end
      end
   endtask

   initial begin
      int p_alu, p_lsu;
      lost_cycles        = 0;
      m_wen              = 1'b0;
      m_addr             = 5'd0;
      m_data             = '0;
      alu_consumed       = 1'b0;
      bus.alu_valid_i    = 1'b0;
      bus.alu_rd_i       = 5'd0;
      bus.alu_data_i     = '0;
      bus.lsu_valid_i    = 1'b0;
      bus.lsu_rd_i       = 5'd0;
      bus.lsu_data_i     = '0;
      bus.rs1_addr_i     = 5'd0;
      bus.rs2_addr_i     = 5'd0;

      for (int cyc = 0; cyc < CYCLES; cyc++) begin
         case (cyc / 500)
            0:       begin p_alu = 90;  p_lsu = 90; end
            1:       begin p_alu = 20;  p_lsu = 60; end
            2:       begin p_alu = 100; p_lsu = 70; end
            default: begin p_alu = 50;  p_lsu = 30; end
         endcase

         @(posedge clk);
         #1;
         rst = (cyc < 3) || ($urandom_range(0, 199) == 0);

         // ALU upstream holds a result until it has been consumed
         if (!bus.alu_valid_i || alu_consumed) begin
            bus.alu_valid_i = ($urandom_range(0, 99) < p_alu);
            bus.alu_rd_i    = 5'($urandom_range(0, 7));
            bus.alu_data_i  = {$urandom, $urandom};
         end
         bus.lsu_valid_i = ($urandom_range(0, 99) < p_lsu);
         bus.lsu_rd_i    = 5'($urandom_range(0, 7));
         bus.lsu_data_i  = {$urandom, $urandom};
         bus.rs1_addr_i  = 5'($urandom_range(0, 7));
         bus.rs2_addr_i  = 5'($urandom_range(0, 7));

         @(negedge clk);
         model_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
